// File: rtl/brf_pkg.sv
// Shared types and width helpers for the banked register file.
package brf_pkg;

  // Copy sequencer states
  typedef enum logic {
    IDLE = 1'b0,
    COPY = 1'b1
  } brf_state_e;

  // Index width for n entries, never narrower than one bit
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bank-level width for n banks, never narrower than one bit
  function automatic int unsigned lvl_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/brf_copy_seq.sv
// Walks the banked register range one register per cycle after an interrupt entry.
module brf_copy_seq
  import brf_pkg::*;
#(
  parameter int unsigned NREG      = 32,
  parameter int unsigned SHADOW_LO = 1,
  parameter int unsigned SHADOW_HI = 15
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  output logic                     busy,
  output logic [addr_w(NREG)-1:0]  copy_addr,
  output logic                     copy_last_c
);

  localparam int unsigned AW = addr_w(NREG);

  brf_state_e      state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;

  // Last copy cycle is the one that moves the top of the banked range
  always_comb begin
    copy_last_c = (addr_q == AW'(SHADOW_HI));
  end

  // Next-state and copy-address stepping
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COPY;
          addr_d  = AW'(SHADOW_LO);
        end
      end
      COPY: begin
        if (copy_last_c) begin
          state_d = IDLE;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers; reset aborts any copy in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign busy      = (state_q == COPY);
  assign copy_addr = addr_q;

endmodule

// File: rtl/banked_reg_file.sv
// Register file with per-interrupt-level shadow banks over a configurable register range.
module banked_reg_file
  import brf_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned NREG          = 32,
  parameter int unsigned NBANK         = 4,
  parameter int unsigned SHADOW_LO     = 1,
  parameter int unsigned SHADOW_HI     = 15,
  parameter int unsigned COPY_ON_ENTRY = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [addr_w(NREG)-1:0]   rs1_addr,
  input  logic [addr_w(NREG)-1:0]   rs2_addr,
  output logic [XLEN-1:0]           rs1_data,
  output logic [XLEN-1:0]           rs2_data,
  input  logic                      wr_en,
  input  logic [addr_w(NREG)-1:0]   wr_addr,
  input  logic [XLEN-1:0]           wr_data,
  input  logic                      freeze,
  input  logic                      irq_enter,
  input  logic                      irq_exit,
  output logic                      busy,
  output logic [lvl_w(NBANK)-1:0]   level,
  output logic                      err_ovf,
  output logic                      err_unf,
  output logic                      err_seq,
  input  logic [addr_w(NREG)-1:0]   dbg_addr,
  output logic [XLEN-1:0]           dbg_data
);

  localparam int unsigned AW = addr_w(NREG);
  localparam int unsigned LW = lvl_w(NBANK);

  logic [XLEN-1:0] regs_q [NBANK][NREG];
  logic [XLEN-1:0] regs_d [NBANK][NREG];

  logic [LW-1:0]   level_q, level_d;
  logic            err_ovf_q, err_ovf_d;
  logic            err_unf_q, err_unf_d;
  logic            err_seq_q, err_seq_d;

  logic            start_copy_c;
  logic            copy_last_c;
  logic [AW-1:0]   copy_addr;
  logic            wr_commit_c;
  logic [LW-1:0]   wr_bank_c, rs1_bank_c, rs2_bank_c, lvl_up_c;

  // Banked addresses follow the active level; everything else lives in bank 0
  function automatic logic [LW-1:0] bank_of(input logic [AW-1:0] a, input logic [LW-1:0] lvl);
    return ((a >= AW'(SHADOW_LO)) && (a <= AW'(SHADOW_HI))) ? lvl : '0;
  endfunction

  brf_copy_seq #(
    .NREG      (NREG),
    .SHADOW_LO (SHADOW_LO),
    .SHADOW_HI (SHADOW_HI)
  ) u_copy_seq (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start_copy_c),
    .busy        (busy),
    .copy_addr   (copy_addr),
    .copy_last_c (copy_last_c)
  );

  // Address resolution and write qualification
  always_comb begin
    wr_commit_c = wr_en && !freeze && !busy && (wr_addr != '0);
    wr_bank_c   = bank_of(wr_addr, level_q);
    rs1_bank_c  = bank_of(rs1_addr, level_q);
    rs2_bank_c  = bank_of(rs2_addr, level_q);
    lvl_up_c    = LW'(level_q + LW'(1));
  end

  // Write-first read ports; equal addresses always resolve to the same bank
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != '0) begin
      rs1_data = (wr_commit_c && (wr_addr == rs1_addr)) ? wr_data : regs_q[rs1_bank_c][rs1_addr];
    end
    if (rs2_addr != '0) begin
      rs2_data = (wr_commit_c && (wr_addr == rs2_addr)) ? wr_data : regs_q[rs2_bank_c][rs2_addr];
    end
  end

  // Debug view of bank 0, no bypass
  always_comb begin
    dbg_data = (dbg_addr == '0) ? '0 : regs_q[0][dbg_addr];
  end

  // Interrupt level control and sticky error detection
  always_comb begin
    level_d      = level_q;
    err_ovf_d    = err_ovf_q;
    err_unf_d    = err_unf_q;
    err_seq_d    = err_seq_q;
    start_copy_c = 1'b0;
    if (irq_enter && irq_exit) begin
      err_seq_d = 1'b1;
    end else if (busy && (irq_enter || irq_exit)) begin
      err_seq_d = 1'b1;
    end else if (irq_enter) begin
      if (level_q == LW'(NBANK - 1)) begin
        err_ovf_d = 1'b1;
      end else if (COPY_ON_ENTRY != 0) begin
        start_copy_c = 1'b1;
      end else begin
        level_d = lvl_up_c;
      end
    end else if (irq_exit) begin
      if (level_q == '0) begin
        err_unf_d = 1'b1;
      end else begin
        level_d = LW'(level_q - LW'(1));
      end
    end
    // The new level becomes visible only once the whole range is copied
    if (busy && copy_last_c) begin
      level_d = lvl_up_c;
    end
  end

  // Storage update: architectural write or one copy step per cycle
  always_comb begin
    regs_d = regs_q;
    if (wr_commit_c) begin
      regs_d[wr_bank_c][wr_addr] = wr_data;
    end
    if (busy) begin
      regs_d[lvl_up_c][copy_addr] = regs_q[level_q][copy_addr];
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int b = 0; b < int'(NBANK); b++) begin
        for (int r = 0; r < int'(NREG); r++) begin
          regs_q[b][r] <= '0;
        end
      end
      level_q   <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
      err_seq_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      level_q   <= level_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
      err_seq_q <= err_seq_d;
    end
  end

  assign level   = level_q;
  assign err_ovf = err_ovf_q;
  assign err_unf = err_unf_q;
  assign err_seq = err_seq_q;

endmodule

// File: tb/tb_banked_reg_file.sv
// Directed self-checking bench for banked_reg_file at default parameters.
module tb_banked_reg_file;

  logic        CLK;
  logic        RST;
  logic [4:0]  rs1_addr, rs2_addr, wr_addr, dbg_addr;
  logic [31:0] rs1_data, rs2_data, wr_data, dbg_data;
  logic        wr_en, freeze, irq_enter, irq_exit;
  logic        busy, err_ovf, err_unf, err_seq;
  logic [1:0]  level;

  int checks;
  int failures;
  int cnt;

  banked_reg_file dut (
    .CLK       (CLK),
    .RST       (RST),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .freeze    (freeze),
    .irq_enter (irq_enter),
    .irq_exit  (irq_exit),
    .busy      (busy),
    .level     (level),
    .err_ovf   (err_ovf),
    .err_unf   (err_unf),
    .err_seq   (err_seq),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance to 1ns after the next rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Count busy cycles starting from the current (already settled) sample
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
      #1;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0; freeze = 0;
    irq_enter = 0; irq_exit = 0; rs1_addr = 5; rs2_addr = 0; dbg_addr = 0;
    tick(); tick();
    RST = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (level !== 2'd0) begin failures++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if ({err_ovf, err_unf, err_seq} !== 3'b000) begin failures++;
      $display("FAIL reset_errs: got %b expected 000", {err_ovf, err_unf, err_seq}); end
    checks++; if (rs1_data !== 32'h0) begin failures++; $display("FAIL reset_r5: got %h expected 0", rs1_data); end
  endtask

  task automatic test_write_read();
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; rs1_addr = 5; dbg_addr = 5;
    #1;
    checks++; if (rs1_data !== 32'hDEADBEEF) begin failures++; $display("FAIL bypass_r5: got %h expected deadbeef", rs1_data); end
    checks++; if (dbg_data !== 32'h0) begin failures++; $display("FAIL dbg_nobypass: got %h expected 0", dbg_data); end
    tick();
    wr_en = 0;
    #1;
    checks++; if (rs1_data !== 32'hDEADBEEF) begin failures++; $display("FAIL stored_r5: got %h expected deadbeef", rs1_data); end
    checks++; if (dbg_data !== 32'hDEADBEEF) begin failures++; $display("FAIL dbg_r5: got %h expected deadbeef", dbg_data); end
    wr_en = 1; wr_addr = 0; wr_data = 32'h1; rs2_addr = 0;
    #1;
    checks++; if (rs2_data !== 32'h0) begin failures++; $display("FAIL r0_bypass: got %h expected 0", rs2_data); end
    tick();
    wr_en = 0;
    #1;
    checks++; if (rs2_data !== 32'h0) begin failures++; $display("FAIL r0_stored: got %h expected 0", rs2_data); end
    wr_en = 1; freeze = 1; wr_addr = 6; wr_data = 32'h66; rs1_addr = 6;
    #1;
    checks++; if (rs1_data !== 32'h0) begin failures++; $display("FAIL freeze_bypass: got %h expected 0", rs1_data); end
    tick();
    wr_en = 0; freeze = 0;
    #1;
    checks++; if (rs1_data !== 32'h0) begin failures++; $display("FAIL freeze_stored: got %h expected 0", rs1_data); end
  endtask

  task automatic test_enter_copy();
    wr_en = 1; wr_addr = 3; wr_data = 32'h11;
    tick();
    wr_en = 0; irq_enter = 1; rs1_addr = 3;
    tick();
    irq_enter = 0;
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL copy_busy_start: got %b expected 1", busy); end
    checks++; if (level !== 2'd0) begin failures++; $display("FAIL copy_level_hold: got %0d expected 0", level); end
    checks++; if (rs1_data !== 32'h11) begin failures++; $display("FAIL copy_read_r3: got %h expected 11", rs1_data); end
    count_busy(cnt);
    checks++; if (cnt !== 15) begin failures++; $display("FAIL copy_len: got %0d expected 15", cnt); end
    checks++; if (level !== 2'd1) begin failures++; $display("FAIL enter_level: got %0d expected 1", level); end
    checks++; if (rs1_data !== 32'h11) begin failures++; $display("FAIL enter_r3: got %h expected 11", rs1_data); end
  endtask

  task automatic test_exit();
    wr_en = 1; wr_addr = 3; wr_data = 32'h22;
    tick();
    wr_addr = 20; wr_data = 32'h33;
    tick();
    wr_en = 0; rs1_addr = 3; rs2_addr = 20; dbg_addr = 3;
    #1;
    checks++; if (rs1_data !== 32'h22) begin failures++; $display("FAIL lvl1_r3: got %h expected 22", rs1_data); end
    checks++; if (dbg_data !== 32'h11) begin failures++; $display("FAIL lvl1_dbg_r3: got %h expected 11", dbg_data); end
    irq_exit = 1;
    tick();
    irq_exit = 0;
    #1;
    checks++; if (level !== 2'd0) begin failures++; $display("FAIL exit_level: got %0d expected 0", level); end
    checks++; if (rs1_data !== 32'h11) begin failures++; $display("FAIL exit_r3: got %h expected 11", rs1_data); end
    checks++; if (rs2_data !== 32'h33) begin failures++; $display("FAIL exit_r20: got %h expected 33", rs2_data); end
  endtask

  task automatic test_overflow_underflow();
    for (int k = 0; k < 3; k++) begin
      irq_enter = 1;
      tick();
      irq_enter = 0;
      #1;
      count_busy(cnt);
    end
    checks++; if (level !== 2'd3) begin failures++; $display("FAIL three_entries_level: got %0d expected 3", level); end
    checks++; if (err_ovf !== 1'b0) begin failures++; $display("FAIL ovf_early: got %b expected 0", err_ovf); end
    irq_enter = 1;
    tick();
    irq_enter = 0;
    #1;
    checks++; if (level !== 2'd3) begin failures++; $display("FAIL ovf_level: got %0d expected 3", level); end
    checks++; if (err_ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b expected 1", err_ovf); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ovf_busy: got %b expected 0", busy); end
    rs1_addr = 3;
    #1;
    checks++; if (rs1_data !== 32'h11) begin failures++; $display("FAIL lvl3_r3: got %h expected 11", rs1_data); end
    for (int k = 0; k < 3; k++) begin
      irq_exit = 1;
      tick();
      irq_exit = 0;
    end
    #1;
    checks++; if (level !== 2'd0) begin failures++; $display("FAIL unwind_level: got %0d expected 0", level); end
    checks++; if (err_unf !== 1'b0) begin failures++; $display("FAIL unf_early: got %b expected 0", err_unf); end
    irq_exit = 1;
    tick();
    irq_exit = 0;
    #1;
    checks++; if (err_unf !== 1'b1) begin failures++; $display("FAIL unf_flag: got %b expected 1", err_unf); end
    checks++; if (level !== 2'd0) begin failures++; $display("FAIL unf_level: got %0d expected 0", level); end
  endtask

  task automatic test_seq_err();
    rs1_addr = 20;
    irq_enter = 1;
    tick();
    irq_enter = 0;
    #1;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt == 3) begin
        irq_enter = 1; wr_en = 1; wr_addr = 20; wr_data = 32'h55;
        #1;
        checks++; if (rs1_data !== 32'h33) begin failures++; $display("FAIL busy_nobypass: got %h expected 33", rs1_data); end
      end
      tick();
      irq_enter = 0; wr_en = 0;
      #1;
    end
    checks++; if (cnt !== 15) begin failures++; $display("FAIL seq_copy_len: got %0d expected 15", cnt); end
    checks++; if (err_seq !== 1'b1) begin failures++; $display("FAIL seq_flag: got %b expected 1", err_seq); end
    checks++; if (level !== 2'd1) begin failures++; $display("FAIL seq_level: got %0d expected 1", level); end
    checks++; if (rs1_data !== 32'h33) begin failures++; $display("FAIL seq_write_dropped: got %h expected 33", rs1_data); end
    checks++; if ({err_ovf, err_unf} !== 2'b11) begin failures++; $display("FAIL sticky_flags: got %b expected 11", {err_ovf, err_unf}); end
  endtask

  task automatic test_rst_mid_copy();
    rs1_addr = 3;
    irq_enter = 1;
    tick();
    irq_enter = 0;
    repeat (4) tick();
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pre_rst_busy: got %b expected 1", busy); end
    RST = 1;
    tick();
    RST = 0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (level !== 2'd0) begin failures++; $display("FAIL rst_level: got %0d expected 0", level); end
    checks++; if (rs1_data !== 32'h0) begin failures++; $display("FAIL rst_r3: got %h expected 0", rs1_data); end
    checks++; if ({err_ovf, err_unf, err_seq} !== 3'b000) begin failures++;
      $display("FAIL rst_errs: got %b expected 000", {err_ovf, err_unf, err_seq}); end
    tick();
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy_hold: got %b expected 0", busy); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_write_read();
    test_enter_copy();
    test_exit();
    test_overflow_underflow();
    test_seq_err();
    test_rst_mid_copy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
